// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard constants, prefix FSM states and keymap entry type.
package kbd_pkg;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_E1      = 8'hE1;
    localparam logic [7:0] SC_F0      = 8'hF0;

    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_RUSLAT  = 8'h58;

    localparam int unsigned PAUSE_LEN   = 7;
    localparam int unsigned PAUSE_CNT_W = 3;
    localparam int unsigned IDX_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_PAUSE
    } kbd_state_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } keymap_t;

    function automatic keymap_t km(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
        keymap_t m;
        m.hit = 1'b1;
        m.row = r;
        m.col = c;
        return m;
    endfunction

endpackage

// File: rtl/kbd_keymap.sv
// Scancode to matrix position lookup: common keys first, then the selected layout.
module kbd_keymap
    import kbd_pkg::*;
#(
    parameter int unsigned LAYOUTS = 2
) (
    input  logic [7:0]                 i_code,
    input  logic [$clog2(LAYOUTS)-1:0] i_layout,
    output keymap_t                    o_map_c
);

    localparam int unsigned LW = $clog2(LAYOUTS);

    keymap_t w_common;
    keymap_t w_qwerty;
    keymap_t w_jcuken;

    // Layout-independent keys live in row 0
    always_comb begin
        w_common = '0;
        case (i_code)
            8'h29:   w_common = km(3'd0, 3'd0);
            8'h66:   w_common = km(3'd0, 3'd1);
            8'h5A:   w_common = km(3'd0, 3'd2);
            8'h76:   w_common = km(3'd0, 3'd3);
            8'h6B:   w_common = km(3'd0, 3'd4);
            8'h74:   w_common = km(3'd0, 3'd5);
            8'h75:   w_common = km(3'd0, 3'd6);
            8'h72:   w_common = km(3'd0, 3'd7);
            default: w_common = '0;
        endcase
    end

    always_comb begin
        w_qwerty = '0;
        case (i_code)
            8'h1C:   w_qwerty = km(3'd4, 3'd1);
            8'h1B:   w_qwerty = km(3'd4, 3'd2);
            8'h23:   w_qwerty = km(3'd4, 3'd3);
            8'h15:   w_qwerty = km(3'd5, 3'd1);
            8'h1D:   w_qwerty = km(3'd5, 3'd2);
            8'h24:   w_qwerty = km(3'd5, 3'd3);
            8'h2D:   w_qwerty = km(3'd5, 3'd4);
            default: w_qwerty = '0;
        endcase
    end

    always_comb begin
        w_jcuken = '0;
        case (i_code)
            8'h1C:   w_jcuken = km(3'd4, 3'd6);
            8'h1B:   w_jcuken = km(3'd4, 3'd7);
            8'h23:   w_jcuken = km(3'd3, 3'd0);
            8'h15:   w_jcuken = km(3'd6, 3'd0);
            8'h1D:   w_jcuken = km(3'd6, 3'd1);
            8'h24:   w_jcuken = km(3'd6, 3'd2);
            8'h2D:   w_jcuken = km(3'd6, 3'd3);
            default: w_jcuken = '0;
        endcase
    end

    always_comb begin
        o_map_c = '0;
        if (w_common.hit)
            o_map_c = w_common;
        else if (i_layout == LW'(0))
            o_map_c = w_qwerty;
        else if (i_layout == LW'(1))
            o_map_c = w_jcuken;
    end

endmodule

// File: rtl/kbd_matrix_tracker.sv
// Tracks held keys from a PS/2 byte stream into a row/column matrix the CPU scans
// with active-low row selects, plus Shift/Ctrl/RUS-LAT modifier levels.
module kbd_matrix_tracker
    import kbd_pkg::*;
#(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned LAYOUTS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 scancode,
    input  logic                       scan_valid,
    input  logic [$clog2(LAYOUTS)-1:0] layout,
    input  logic [ROWS-1:0]            rowsel,
    output logic [COLS-1:0]            cols,
    output logic                       key_ss,
    output logic                       key_us,
    output logic                       key_rus,
    output logic                       qerror
);

    kbd_state_t                      r_state;
    logic [PAUSE_CNT_W-1:0]          r_pause_cnt;
    logic [ROWS-1:0][COLS-1:0]       r_matrix;
    logic [COLS-1:0]                 r_cols;
    logic                            r_key_ss;
    logic                            r_key_us;
    logic                            r_key_rus;
    logic                            r_qerror;
    logic [$clog2(LAYOUTS)-1:0]      r_layout;

    keymap_t                         w_map;
    logic                            w_layout_chg;
    logic                            w_prefix;
    logic                            w_act;
    logic                            w_brk;
    logic                            w_is_ss;
    logic                            w_is_us;
    logic                            w_is_rus;
    logic                            w_in_range;
    logic [COLS-1:0]                 w_sel;

    kbd_keymap #(.LAYOUTS(LAYOUTS)) u_keymap (
        .i_code   (scancode),
        .i_layout (layout),
        .o_map_c  (w_map)
    );

    assign w_layout_chg = (layout != r_layout);
    assign w_prefix     = ((r_state == ST_IDLE) &&
                           (scancode == SC_F0 || scancode == SC_E0 || scancode == SC_E1)) ||
                          ((r_state == ST_EXT) && (scancode == SC_F0));
    assign w_act        = scan_valid && !w_layout_chg && (r_state != ST_PAUSE) && !w_prefix;
    assign w_brk        = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    assign w_is_ss      = (scancode == SC_LSHIFT) || (scancode == SC_RSHIFT);
    assign w_is_us      = (scancode == SC_CTRL);
    assign w_is_rus     = (scancode == SC_RUSLAT);
    assign w_in_range   = w_map.hit && (32'(w_map.row) < ROWS) && (32'(w_map.col) < COLS);

    // Columns read low for any held key in a selected (low) row
    always_comb begin
        w_sel = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (!rowsel[r])
                w_sel = w_sel | r_matrix[r];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pause_cnt <= '0;
            r_matrix    <= '0;
            r_cols      <= '1;
            r_key_ss    <= 1'b0;
            r_key_us    <= 1'b0;
            r_key_rus   <= 1'b0;
            r_qerror    <= 1'b0;
            r_layout    <= '0;
        end else begin
            r_layout <= layout;
            r_cols   <= ~w_sel;
            r_qerror <= 1'b0;
            if (w_layout_chg) begin
                r_state     <= ST_IDLE;
                r_pause_cnt <= '0;
                r_matrix    <= '0;
                r_key_ss    <= 1'b0;
                r_key_us    <= 1'b0;
                r_key_rus   <= 1'b0;
            end else if (scan_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (scancode == SC_F0)
                            r_state <= ST_BRK;
                        else if (scancode == SC_E0)
                            r_state <= ST_EXT;
                        else if (scancode == SC_E1) begin
                            r_state     <= ST_PAUSE;
                            r_pause_cnt <= '0;
                        end
                    end
                    ST_EXT:
                        r_state <= (scancode == SC_F0) ? ST_EXT_BRK : ST_IDLE;
                    ST_PAUSE: begin
                        if (r_pause_cnt == PAUSE_CNT_W'(PAUSE_LEN - 1)) begin
                            r_state     <= ST_IDLE;
                            r_pause_cnt <= '0;
                        end else begin
                            r_pause_cnt <= r_pause_cnt + PAUSE_CNT_W'(1);
                        end
                    end
                    default:
                        r_state <= ST_IDLE;
                endcase

                // Modifiers never reach the matrix; unmapped breaks are silent
                if (w_act) begin
                    if (w_is_ss)
                        r_key_ss <= !w_brk;
                    else if (w_is_us)
                        r_key_us <= !w_brk;
                    else if (w_is_rus)
                        r_key_rus <= !w_brk;
                    else if (w_in_range) begin
                        for (int r = 0; r < int'(ROWS); r++) begin
                            for (int c = 0; c < int'(COLS); c++) begin
                                if (IDX_W'(r) == w_map.row && IDX_W'(c) == w_map.col)
                                    r_matrix[r][c] <= !w_brk;
                            end
                        end
                    end else if (!w_brk)
                        r_qerror <= 1'b1;
                end
            end
        end
    end

    assign cols    = r_cols;
    assign key_ss  = r_key_ss;
    assign key_us  = r_key_us;
    assign key_rus = r_key_rus;
    assign qerror  = r_qerror;

endmodule

// File: tb/tb_kbd_matrix_tracker.sv
// Directed-vector bench for kbd_matrix_tracker with hand-computed expectations.
module tb_kbd_matrix_tracker;

    logic       clk;
    logic       reset;
    logic [7:0] scancode;
    logic       scan_valid;
    logic [0:0] layout;
    logic [7:0] rowsel;
    logic [7:0] cols;
    logic       key_ss;
    logic       key_us;
    logic       key_rus;
    logic       qerror;

    int n_vec;
    int n_err;

    kbd_matrix_tracker #(.ROWS(8), .COLS(8), .LAYOUTS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scancode   (scancode),
        .scan_valid (scan_valid),
        .layout     (layout),
        .rowsel     (rowsel),
        .cols       (cols),
        .key_ss     (key_ss),
        .key_us     (key_us),
        .key_rus    (key_rus),
        .qerror     (qerror)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic send(input logic [7:0] b);
        scancode   = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic rd_cols(input string tag, input logic [7:0] rs, input logic [7:0] exp);
        rowsel = rs;
        @(negedge clk);
        check_vec(tag, cols, exp);
    endtask

    task automatic set_layout(input logic [0:0] l);
        layout = l;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        scancode   = 8'h00;
        scan_valid = 1'b0;
        layout     = 1'b0;
        rowsel     = 8'hFF;
        repeat (3) @(negedge clk);
        check_vec("rst_cols",   cols,           8'hFF);
        check_vec("rst_qerror", 8'(qerror),     8'h00);
        reset = 1'b0;
        @(negedge clk);
        check_vec("post_rst_cols", cols,        8'hFF);
        check_vec("rst_ss",     8'(key_ss),     8'h00);
        check_vec("rst_us",     8'(key_us),     8'h00);
        check_vec("rst_rus",    8'(key_rus),    8'h00);

        // QWERTY A at row 4 col 1, then release
        send(8'h1C);
        rd_cols("qwerty_a_make", 8'hEF, 8'hFD);
        rd_cols("qwerty_a_row0", 8'hFE, 8'hFF);
        send(8'hF0); send(8'h1C);
        rd_cols("qwerty_a_brk",  8'hEF, 8'hFF);

        // JCUKEN maps 1C to row 4 col 6; layout flip clears
        set_layout(1'b1);
        send(8'h1C);
        rd_cols("jcuken_1c",     8'hEF, 8'hBF);
        set_layout(1'b0);
        rd_cols("layout_clear",  8'hEF, 8'hFF);

        // Byte coincident with a layout change is dropped, modifiers cleared
        send(8'h12);
        check_vec("ss_before_chg", 8'(key_ss), 8'h01);
        layout     = 1'b1;
        scancode   = 8'h5A;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        check_vec("ss_after_chg", 8'(key_ss), 8'h00);
        rd_cols("chg_byte_drop", 8'hFE, 8'hFF);
        set_layout(1'b0);

        // Extended code E0 6B looks up as 6B
        send(8'hE0); send(8'h6B);
        rd_cols("ext_make",      8'hFE, 8'hEF);
        send(8'hE0); send(8'hF0); send(8'h6B);
        rd_cols("ext_brk",       8'hFE, 8'hFF);
        send(8'hE0); send(8'h6B);
        send(8'hE0);
        pulse_reset();
        send(8'hF0); send(8'h6B);
        rd_cols("rst_mid_brk",   8'hFE, 8'hFF);
        send(8'h5A);
        rd_cols("rst_mid_next",  8'hFE, 8'hFB);
        send(8'hF0); send(8'h5A);

        // Pause sequence swallows seven bytes
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check_vec("pause_qerr",  8'(qerror), 8'h00);
        check_vec("pause_us",    8'(key_us), 8'h00);
        rd_cols("pause_matrix",  8'h00, 8'hFF);
        send(8'h5A);
        rd_cols("pause_idle",    8'hFE, 8'hFB);
        send(8'hF0); send(8'h5A);

        // Modifiers and unmapped codes
        send(8'h12);
        check_vec("ss_make",     8'(key_ss), 8'h01);
        rd_cols("ss_no_matrix",  8'h00, 8'hFF);
        send(8'h01);
        check_vec("qerr_pulse",  8'(qerror), 8'h01);
        @(negedge clk);
        check_vec("qerr_once",   8'(qerror), 8'h00);
        send(8'hF0); send(8'h12);
        check_vec("ss_brk",      8'(key_ss), 8'h00);
        send(8'h59);
        check_vec("rshift_make", 8'(key_ss), 8'h01);
        send(8'hF0); send(8'h59);
        check_vec("rshift_brk",  8'(key_ss), 8'h00);
        send(8'hE0); send(8'h14);
        check_vec("ext_ctrl",    8'(key_us), 8'h01);
        send(8'hF0); send(8'h14);
        check_vec("ctrl_brk",    8'(key_us), 8'h00);
        send(8'h58);
        check_vec("rus_make",    8'(key_rus), 8'h01);
        send(8'hF0); send(8'h58);
        check_vec("rus_brk",     8'(key_rus), 8'h00);
        send(8'hF0); send(8'h01);
        check_vec("unmapped_brk", 8'(qerror), 8'h00);

        // Typematic repeat then single release
        send(8'h5A); send(8'h5A);
        rd_cols("typematic_set", 8'hFE, 8'hFB);
        send(8'hF0); send(8'h5A);
        rd_cols("typematic_clr", 8'hFE, 8'hFF);

        // Two rows selected together
        send(8'h5A); send(8'h1C);
        rd_cols("two_rows",      8'hEE, 8'hF9);
        rd_cols("no_rows",       8'hFF, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
